smc_cycle_seq: RTL and testbench
================================

SMC_CYCLE_SEQ -- requirements
Module: smc_cycle_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the access wait-state count and counter.
REQ-002 SHALL have port hclk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port n_sys_reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 1, transfer request; sampled only in IDLE.
REQ-005 SHALL have port wr, input, 1, direction, 1=write, 0=read; captured with req.
REQ-006 SHALL have port cfg_setup, input, 4, setup wait states, CS asserted before strobe.
REQ-007 SHALL have port cfg_access, input, CNT_W, access wait states; strobe width is cfg_access+1 cycles.
REQ-008 SHALL have port cfg_hold, input, 4, hold cycles after strobe, CS still asserted.
REQ-009 SHALL have port cfg_turn, input, 4, bus turnaround idle cycles after hold.
REQ-010 SHALL have port n_ext_wait, input, 1, external wait, active low, stretches ACCESS.
REQ-011 SHALL have port ack, output, 1, single-cycle completion pulse.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have ports cs_n, oe_n, we_n, output, 1 each, active-low memory chip-select, output-enable, write-enable.

Function
REQ-014 SHALL implement states IDLE, SETUP, ACCESS, HOLD, TURN; all outputs registered.
REQ-015 SHALL, in IDLE with req=1, capture wr, cfg_setup, cfg_access, cfg_hold, cfg_turn; the next state is SETUP if cfg_setup!=0, else ACCESS.
REQ-016 SHALL ignore cfg_* and wr changes after capture until the next IDLE acceptance.
REQ-017 SHALL stay in SETUP exactly captured cfg_setup cycles, then enter ACCESS.
REQ-018 SHALL stay in ACCESS captured cfg_access+1 cycles; cfg_access=0 gives 1 cycle; all-ones gives 2^CNT_W cycles without wrap.
REQ-019 SHALL pulse ack high for exactly the last ACCESS cycle of each transfer.
REQ-020 SHALL leave ACCESS for HOLD if cfg_hold!=0, else TURN if cfg_turn!=0, else IDLE.
REQ-021 SHALL leave HOLD after captured cfg_hold cycles for TURN if cfg_turn!=0, else IDLE.
REQ-022 SHALL leave TURN for IDLE after captured cfg_turn cycles.
REQ-023 SHALL drive cs_n=0 in SETUP, ACCESS, HOLD; cs_n=1 in IDLE and TURN.
REQ-024 SHALL drive oe_n=0 only in ACCESS with captured wr=0, and we_n=0 only in ACCESS with captured wr=1.
REQ-025 SHALL ignore req outside IDLE; a req held high across completion is accepted in the first IDLE cycle.
REQ-026 SHALL return to IDLE for one cycle between back-to-back transfers, min gap one cycle with cs_n=1.

Reset
REQ-027 SHALL, on n_sys_reset low, immediately and asynchronously force IDLE, counters 0, cs_n=oe_n=we_n=1, ack=0, busy=0.
REQ-028 SHALL, on reset mid-transfer, abort without ack; first req is sampled on the first rising edge after n_sys_reset deasserts.

Configuration
REQ-029 SHALL, with SMC_EXT_WAIT_EN defined, hold the ACCESS counter and suppress ack while n_ext_wait=0 on the final ACCESS count; completion occurs in the first cycle n_ext_wait=1.
REQ-030 SHALL, without SMC_EXT_WAIT_EN, keep the n_ext_wait port but ignore it; ACCESS duration is fixed by cfg_access.

Verification
REQ-031 SHALL cover: read, setup=2, access=3, hold=1, turn=0 -> cs_n low 7 cycles, oe_n low 4 cycles, ack in 4th oe_n cycle, we_n stays 1.
REQ-032 SHALL cover: write, all cfg=0 -> ACCESS one cycle, we_n and cs_n low 1 cycle with ack, busy 1 cycle, next req accepted after one IDLE cycle.
REQ-033 SHALL cover: cfg_access changed 5->1 during SETUP of write with access=5 -> strobe still 6 cycles.
REQ-034 SHALL cover: n_sys_reset asserted in 3rd ACCESS cycle -> outputs return to reset values same cycle, no ack.
REQ-035 SHALL cover: SMC_EXT_WAIT_EN defined, access=1, n_ext_wait low 3 cycles from ACCESS start -> strobe 4 cycles, ack in 4th; without macro -> strobe 2 cycles.
REQ-036 SHALL cover: req held high, turn=2 -> cs_n high 3 cycles (2 TURN + 1 IDLE) between transfers.

Source files
------------

// File: rtl/smc_cycle_seq.sv
// Static memory controller cycle sequencer: IDLE -> SETUP -> ACCESS -> HOLD -> TURN.
// Optional feature macro: SMC_EXT_WAIT_EN. When defined, n_ext_wait (sampled on the
// rising edge of hclk) stretches the final ACCESS count. When undefined, the port is
// present but ignored.
module smc_cycle_seq #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             hclk,
   input  logic             n_sys_reset,
   input  logic             req,
   input  logic             wr,
   input  logic [3:0]       cfg_setup,
   input  logic [CNT_W-1:0] cfg_access,
   input  logic [3:0]       cfg_hold,
   input  logic [3:0]       cfg_turn,
   input  logic             n_ext_wait,
   output logic             ack,
   output logic             busy,
   output logic             cs_n,
   output logic             oe_n,
   output logic             we_n
);

   typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StTurn} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [CNT_W-1:0] access_q, access_d;
   logic [3:0]       hold_q, hold_d;
   logic [3:0]       turn_q, turn_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;
   logic             cs_n_q, cs_n_d;
   logic             oe_n_q, oe_n_d;
   logic             we_n_q, we_n_d;
   logic             ext_ok;

`ifdef SMC_EXT_WAIT_EN
   assign ext_ok = n_ext_wait;
`else
   logic unused_n_ext_wait;
   assign unused_n_ext_wait = n_ext_wait;
   assign ext_ok = 1'b1;
`endif

   // Counter load for a 4-bit phase length (caller guarantees v != 0).
   function automatic logic [CNT_W-1:0] ld4(input logic [3:0] v);
      return CNT_W'(v - 4'd1);
   endfunction

   // Next-state, counter and registered-output decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      access_d = access_q;
      hold_d   = hold_q;
      turn_d   = turn_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               wr_d     = wr;
               access_d = cfg_access;
               hold_d   = cfg_hold;
               turn_d   = cfg_turn;
               if (cfg_setup != 4'd0) begin
                  state_d = StSetup;
                  cnt_d   = ld4(cfg_setup);
               end else begin
                  state_d = StAccess;
                  cnt_d   = cfg_access;
               end
            end
         end
         StSetup: begin
            if (cnt_q == '0) begin
               state_d = StAccess;
               cnt_d   = access_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StAccess: begin
            // ack_q marks the cycle just completed as the final strobe cycle.
            if (ack_q) begin
               if (hold_q != 4'd0) begin
                  state_d = StHold;
                  cnt_d   = ld4(hold_q);
               end else if (turn_q != 4'd0) begin
                  state_d = StTurn;
                  cnt_d   = ld4(turn_q);
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               if (turn_q != 4'd0) begin
                  state_d = StTurn;
                  cnt_d   = ld4(turn_q);
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StTurn: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // Outputs are a function of the state being entered, so they register with it.
      ack_d  = (state_d == StAccess) && (cnt_d == '0) && ext_ok;
      busy_d = (state_d != StIdle);
      cs_n_d = !((state_d == StSetup) || (state_d == StAccess) || (state_d == StHold));
      oe_n_d = !((state_d == StAccess) && !wr_d);
      we_n_d = !((state_d == StAccess) && wr_d);
   end

   // State, captured configuration and registered outputs.
   always_ff @(posedge hclk or negedge n_sys_reset) begin
      if (!n_sys_reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         access_q <= '0;
         hold_q   <= 4'd0;
         turn_q   <= 4'd0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         access_q <= access_d;
         hold_q   <= hold_d;
         turn_q   <= turn_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         cs_n_q   <= cs_n_d;
         oe_n_q   <= oe_n_d;
         we_n_q   <= we_n_d;
      end
   end

   assign ack  = ack_q;
   assign busy = busy_q;
   assign cs_n = cs_n_q;
   assign oe_n = oe_n_q;
   assign we_n = we_n_q;

endmodule

// File: tb/tb_smc_cycle_seq.sv
// Scoreboard bench for smc_cycle_seq: stimulus pushes expected transfer shapes, a
// negedge monitor measures cs_n/strobe/ack/gap and compares against the queue head.
module tb_smc_cycle_seq;

   localparam int unsigned CNT_W = 8;

   logic             hclk        = 1'b0;
   logic             n_sys_reset = 1'b0;
   logic             req         = 1'b0;
   logic             wr          = 1'b0;
   logic [3:0]       cfg_setup   = 4'd0;
   logic [CNT_W-1:0] cfg_access  = '0;
   logic [3:0]       cfg_hold    = 4'd0;
   logic [3:0]       cfg_turn    = 4'd0;
   logic             n_ext_wait  = 1'b1;
   logic             ack, busy, cs_n, oe_n, we_n;

   smc_cycle_seq #(.CNT_W(CNT_W)) dut (
      .hclk        (hclk),
      .n_sys_reset (n_sys_reset),
      .req         (req),
      .wr          (wr),
      .cfg_setup   (cfg_setup),
      .cfg_access  (cfg_access),
      .cfg_hold    (cfg_hold),
      .cfg_turn    (cfg_turn),
      .n_ext_wait  (n_ext_wait),
      .ack         (ack),
      .busy        (busy),
      .cs_n        (cs_n),
      .oe_n        (oe_n),
      .we_n        (we_n)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      logic wr;
      int   strobe;
      int   cs_len;
      int   gap;     // cs_n-high cycles before this transfer, -1 = don't care
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_err  = 0;
   int   n_done = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: measure each cs_n-low window and compare with the scoreboard head.
   int   cs_run = 0, oe_run = 0, we_run = 0, ack_cnt = 0, hi_run = 0, start_gap = 0;
   bit   in_xfer = 1'b0;
   exp_t e;

   always @(negedge hclk) begin
      if (!n_sys_reset) begin
         in_xfer = 1'b0;
         hi_run  = 0;
         cs_run  = 0;
      end else if (!cs_n) begin
         if (!in_xfer) begin
            in_xfer   = 1'b1;
            start_gap = hi_run;
            cs_run    = 0;
            oe_run    = 0;
            we_run    = 0;
            ack_cnt   = 0;
         end
         cs_run++;
         if (!oe_n) oe_run++;
         if (!we_n) we_run++;
         if (!busy) chk("busy_during_cs", busy, 1);
         if (ack) begin
            ack_cnt++;
            if (sb.size() == 0) begin
               chk("ack_without_request", ack, 0);
            end else begin
               e = sb[0];
               chk("strobe_len_at_ack", e.wr ? we_run : oe_run, e.strobe);
               chk("wrong_strobe_cycles", e.wr ? oe_run : we_run, 0);
            end
         end
      end else begin
         if (in_xfer) begin
            in_xfer = 1'b0;
            if (sb.size() == 0) begin
               chk("transfer_without_request", cs_run, 0);
            end else begin
               e = sb.pop_front();
               chk("cs_low_len", cs_run, e.cs_len);
               chk("ack_pulses", ack_cnt, 1);
               if (e.gap >= 0) chk("cs_high_gap", start_gap, e.gap);
               n_done++;
            end
            hi_run = 0;
         end
         hi_run++;
         if (!oe_n || !we_n || ack) chk("outputs_with_cs_high", {oe_n, we_n, ack}, 3'b110);
      end
   end

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge hclk);
         #1;
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk("wait_idle_timeout", busy, 0);
   endtask

   // Single transfer; after acceptance the inputs are disturbed to prove capture.
   task automatic xfer(input logic w, input logic [3:0] s, input logic [CNT_W-1:0] a,
                       input logic [3:0] h, input logic [3:0] t,
                       input int strobe, input int cs_len);
      bit got = 1'b0;
      sb.push_back('{wr: w, strobe: strobe, cs_len: cs_len, gap: -1});
      wr = w; cfg_setup = s; cfg_access = a; cfg_hold = h; cfg_turn = t;
      req = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge hclk);
         #1;
         if (busy) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("accept_timeout", busy, 1);
      req = 1'b0;
      wr = ~w; cfg_setup = 4'hf; cfg_access = CNT_W'(1); cfg_hold = 4'hf; cfg_turn = 4'hf;
      wait_idle();
   endtask

   // Two transfers with req held high across the first completion.
   task automatic xfer_pair(input logic w, input logic [3:0] s, input logic [CNT_W-1:0] a,
                            input logic [3:0] h, input logic [3:0] t,
                            input int strobe, input int cs_len, input int gap2);
      int   acc  = 0;
      logic prev = 1'b0;
      sb.push_back('{wr: w, strobe: strobe, cs_len: cs_len, gap: -1});
      sb.push_back('{wr: w, strobe: strobe, cs_len: cs_len, gap: gap2});
      wr = w; cfg_setup = s; cfg_access = a; cfg_hold = h; cfg_turn = t;
      req = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(posedge hclk);
         #1;
         if (busy && !prev) acc++;
         prev = busy;
         if (acc == 2) break;
      end
      if (acc != 2) chk("pair_accept_count", acc, 2);
      req = 1'b0;
      wait_idle();
   endtask

   initial begin
      int ext_strobe;
      // Reset values while reset is held
      #12;
      chk("rst_cs_n", cs_n, 1);
      chk("rst_oe_n", oe_n, 1);
      chk("rst_we_n", we_n, 1);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      n_sys_reset = 1'b1;
      @(posedge hclk);
      #1;

      // read: setup 2, access 3, hold 1, turn 0 -> strobe 4, cs 7
      xfer(1'b0, 4'd2, CNT_W'(3), 4'd1, 4'd0, 4, 7);
      // write, all zero, back-to-back with one IDLE cycle between
      xfer_pair(1'b1, 4'd0, CNT_W'(0), 4'd0, 4'd0, 1, 1, 1);
      // write access 5; cfg_access becomes 1 during SETUP -> strobe still 6
      xfer(1'b1, 4'd2, CNT_W'(5), 4'd0, 4'd0, 6, 8);
      // read, turn 2, req held -> 2 TURN + 1 IDLE gap
      xfer_pair(1'b0, 4'd0, CNT_W'(0), 4'd0, 4'd2, 1, 1, 3);
      // write: setup 1, access 2, hold 2, turn 1 -> strobe 3, cs 6
      xfer(1'b1, 4'd1, CNT_W'(2), 4'd2, 4'd1, 3, 6);
      // read, access all-ones -> 2^CNT_W strobe cycles without wrap
      xfer(1'b0, 4'd0, {CNT_W{1'b1}}, 4'd0, 4'd0, 256, 256);

      // External wait: low at the edges entering ACCESS cycles 1..3
`ifdef SMC_EXT_WAIT_EN
      ext_strobe = 4;
`else
      ext_strobe = 2;
`endif
      sb.push_back('{wr: 1'b0, strobe: ext_strobe, cs_len: ext_strobe, gap: -1});
      wr = 1'b0; cfg_setup = 4'd0; cfg_access = CNT_W'(1); cfg_hold = 4'd0; cfg_turn = 4'd0;
      n_ext_wait = 1'b0;
      req = 1'b1;
      @(posedge hclk);
      #1;
      req = 1'b0;
      chk("ext_accept_busy", busy, 1);
      @(posedge hclk);
      @(posedge hclk);
      #1;
      n_ext_wait = 1'b1;
      wait_idle();

      // Reset in the 3rd ACCESS cycle of a long write: abort, no ack
      wr = 1'b1; cfg_setup = 4'd0; cfg_access = CNT_W'(5); cfg_hold = 4'd0; cfg_turn = 4'd0;
      req = 1'b1;
      @(posedge hclk);
      #1;
      req = 1'b0;
      chk("abort_accept_busy", busy, 1);
      @(posedge hclk);
      @(posedge hclk);
      #2;
      chk("abort_we_before_reset", we_n, 0);
      n_sys_reset = 1'b0;
      #1;
      chk("abort_cs_n", cs_n, 1);
      chk("abort_oe_n", oe_n, 1);
      chk("abort_we_n", we_n, 1);
      chk("abort_ack", ack, 0);
      chk("abort_busy", busy, 0);
      // First req after release is taken on the first rising edge
      sb.push_back('{wr: 1'b0, strobe: 1, cs_len: 1, gap: -1});
      wr = 1'b0; cfg_access = CNT_W'(0);
      req = 1'b1;
      @(negedge hclk);
      #2;
      n_sys_reset = 1'b1;
      @(posedge hclk);
      #1;
      chk("first_req_after_reset", busy, 1);
      req = 1'b0;
      wait_idle();

      repeat (3) @(posedge hclk);
      #1;
      chk("transfers_completed", n_done, 10);
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
